// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: combinational forwarding selects and stall/bubble enables;
// hz_state, stall_count and mem_timeout are registered one edge after the condition.
module hazard_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rs_ID,
  input  logic        uses_rt_ID,
  input  logic [4:0]  WriteDestination_EX,
  input  logic [4:0]  WriteDestination_MEM,
  input  logic [4:0]  WriteDestination_WB,
  input  logic        RegFileEnable_EX,
  input  logic        RegFileEnable_MEM,
  input  logic        RegFileEnable_WB,
  input  logic        MemLoad_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic        PC_LE,
  output logic        IF_ID_LE,
  output logic        ID_EX_LE,
  output logic        EX_MEM_LE,
  output logic        MEM_WB_LE,
  output logic        ID_EX_bubble,
  output logic [1:0]  hz_state,
  output logic [15:0] stall_count,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } hz_state_e;

  hz_state_e   state_q, state_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic        mem_wait;
  logic        load_use;
  logic        any_stall;

  function automatic logic [1:0] fwd_select(input logic [4:0] src, input logic uses,
                                            input logic en_ex, input logic [4:0] dst_ex,
                                            input logic en_mem, input logic [4:0] dst_mem,
                                            input logic en_wb, input logic [4:0] dst_wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && src != 5'd0) begin
      if (en_ex && dst_ex == src)        sel = 2'b01;
      else if (en_mem && dst_mem == src) sel = 2'b10;
      else if (en_wb && dst_wb == src)   sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    mem_wait = mem_req_MEM & ~mem_ready;
    load_use = MemLoad_EX & RegFileEnable_EX & (WriteDestination_EX != 5'd0) &
               ((uses_rs_ID & (rs_ID == WriteDestination_EX)) |
                (uses_rt_ID & (rt_ID == WriteDestination_EX)));
    any_stall = mem_wait | load_use;
  end

  // Reset overrides every combinational output so a mid-stall reset releases the pipeline at once.
  always_comb begin
    fwd_rs_sel   = 2'b00;
    fwd_rt_sel   = 2'b00;
    PC_LE        = 1'b1;
    IF_ID_LE     = 1'b1;
    ID_EX_LE     = 1'b1;
    EX_MEM_LE    = 1'b1;
    MEM_WB_LE    = 1'b1;
    ID_EX_bubble = 1'b0;
    if (!reset) begin
      fwd_rs_sel = fwd_select(rs_ID, uses_rs_ID, RegFileEnable_EX, WriteDestination_EX,
                              RegFileEnable_MEM, WriteDestination_MEM,
                              RegFileEnable_WB, WriteDestination_WB);
      fwd_rt_sel = fwd_select(rt_ID, uses_rt_ID, RegFileEnable_EX, WriteDestination_EX,
                              RegFileEnable_MEM, WriteDestination_MEM,
                              RegFileEnable_WB, WriteDestination_WB);
      if (mem_wait) begin
        // Freezing ID/EX too keeps the load in EX so a pending load-use is re-evaluated later.
        PC_LE     = 1'b0;
        IF_ID_LE  = 1'b0;
        ID_EX_LE  = 1'b0;
        EX_MEM_LE = 1'b0;
        MEM_WB_LE = 1'b0;
      end else if (load_use) begin
        PC_LE        = 1'b0;
        IF_ID_LE     = 1'b0;
        ID_EX_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = RUN;
    stall_count_d = stall_count_q;
    wait_cnt_d    = 8'd0;
    mem_timeout_d = mem_timeout_q;
    if (mem_wait)      state_d = MEM_WAIT;
    else if (load_use) state_d = LOAD_STALL;
    if (any_stall && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
      if (wait_cnt_q == 8'd254) mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      stall_count_q <= 16'd0;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hz_state    = state_q;
  assign stall_count = stall_count_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: driver pushes model-predicted outputs after each rising edge,
// monitor pops and compares on the falling edge.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_ID, rt_ID;
  logic        uses_rs_ID, uses_rt_ID;
  logic [4:0]  WriteDestination_EX, WriteDestination_MEM, WriteDestination_WB;
  logic        RegFileEnable_EX, RegFileEnable_MEM, RegFileEnable_WB;
  logic        MemLoad_EX, mem_req_MEM, mem_ready;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic        PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_LE, ID_EX_bubble;
  logic [1:0]  hz_state;
  logic [15:0] stall_count;
  logic        mem_timeout;

  hazard_control_unit dut (
    .clk(clk), .reset(reset),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
    .WriteDestination_EX(WriteDestination_EX), .WriteDestination_MEM(WriteDestination_MEM),
    .WriteDestination_WB(WriteDestination_WB),
    .RegFileEnable_EX(RegFileEnable_EX), .RegFileEnable_MEM(RegFileEnable_MEM),
    .RegFileEnable_WB(RegFileEnable_WB),
    .MemLoad_EX(MemLoad_EX), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .ID_EX_LE(ID_EX_LE), .EX_MEM_LE(EX_MEM_LE),
    .MEM_WB_LE(MEM_WB_LE), .ID_EX_bubble(ID_EX_bubble),
    .hz_state(hz_state), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic [4:0] le;
    logic       bubble;
    logic [1:0] state;
    logic [15:0] stalls;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pushed = 0;

  // Reference model state: plain integers following the stated rules.
  int m_state = 0;   // 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT
  int m_stalls = 0;
  int m_wait_run = 0;
  bit m_timeout = 0;

  function automatic bit is_mem_wait();
    return mem_req_MEM && !mem_ready;
  endfunction

  function automatic bit is_load_use();
    if (!(MemLoad_EX && RegFileEnable_EX && WriteDestination_EX != 0)) return 0;
    return (uses_rs_ID && rs_ID == WriteDestination_EX) ||
           (uses_rt_ID && rt_ID == WriteDestination_EX);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src, input logic uses);
    if (!uses || src == 0) return 2'd0;
    if (RegFileEnable_EX && WriteDestination_EX == src) return 2'd1;
    if (RegFileEnable_MEM && WriteDestination_MEM == src) return 2'd2;
    if (RegFileEnable_WB && WriteDestination_WB == src) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_edge();
    bit mw, lu;
    mw = is_mem_wait();
    lu = is_load_use();
    if (reset) begin
      m_state = 0; m_stalls = 0; m_wait_run = 0; m_timeout = 0;
    end else begin
      if (mw || lu) m_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;
      m_wait_run = mw ? m_wait_run + 1 : 0;
      if (m_wait_run >= 255) m_timeout = 1;
      m_state = mw ? 2 : (lu ? 1 : 0);
    end
  endtask

  task automatic push();
    exp_t e;
    if (reset) begin
      m_state = 0; m_stalls = 0; m_wait_run = 0; m_timeout = 0;
    end
    e.id = pushed;
    e.rs_sel = reset ? 2'd0 : model_fwd(rs_ID, uses_rs_ID);
    e.rt_sel = reset ? 2'd0 : model_fwd(rt_ID, uses_rt_ID);
    e.bubble = 0;
    if (reset)              e.le = 5'b11111;
    else if (is_mem_wait()) e.le = 5'b00000;
    else if (is_load_use()) begin e.le = 5'b00111; e.bubble = 1; end
    else                    e.le = 5'b11111;
    e.state   = 2'(m_state);
    e.stalls  = 16'(m_stalls);
    e.timeout = m_timeout;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Rising edge: advance the model with the inputs held across it, then step off the edge.
  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0;
    rs_ID = 0; rt_ID = 0; uses_rs_ID = 0; uses_rt_ID = 0;
    WriteDestination_EX = 0; WriteDestination_MEM = 0; WriteDestination_WB = 0;
    RegFileEnable_EX = 0; RegFileEnable_MEM = 0; RegFileEnable_WB = 0;
    MemLoad_EX = 0; mem_req_MEM = 0; mem_ready = 0;
  endtask

  task automatic reset_cycle();
    advance(); clear_inputs(); reset = 1; push();
    advance(); clear_inputs(); push();
  endtask

  task automatic set_load_use();
    MemLoad_EX = 1; RegFileEnable_EX = 1; WriteDestination_EX = 5'd8;
    rt_ID = 5'd8; uses_rt_ID = 1;
  endtask

  task automatic mem_wait_cycles(input int n, input bit with_lu);
    for (int i = 0; i < n; i++) begin
      advance(); clear_inputs();
      if (with_lu) set_load_use();
      mem_req_MEM = 1; mem_ready = 0;
      push();
    end
  endtask

  task automatic check(input string name, input int id, input logic [15:0] got,
                       input logic [15:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        check("fwd_rs_sel", e.id, 16'(fwd_rs_sel), 16'(e.rs_sel));
        check("fwd_rt_sel", e.id, 16'(fwd_rt_sel), 16'(e.rt_sel));
        check("load_enables", e.id, 16'({PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_LE}),
              16'(e.le));
        check("ID_EX_bubble", e.id, 16'(ID_EX_bubble), 16'(e.bubble));
        check("hz_state", e.id, 16'(hz_state), 16'(e.state));
        check("stall_count", e.id, stall_count, e.stalls);
        check("mem_timeout", e.id, 16'(mem_timeout), 16'(e.timeout));
      end
    end
  end

  initial begin : driver
    clear_inputs();
    reset = 1;
    advance(); push();
    advance(); clear_inputs(); push();

    // Forwarding priority EX > MEM, then MEM alone, then x0 never forwards.
    advance(); clear_inputs();
    RegFileEnable_EX = 1; WriteDestination_EX = 5; RegFileEnable_MEM = 1;
    WriteDestination_MEM = 5; rs_ID = 5; uses_rs_ID = 1; push();
    advance(); RegFileEnable_EX = 0; push();
    advance(); rs_ID = 0; push();
    advance(); rs_ID = 5; uses_rs_ID = 0; push();
    advance(); clear_inputs(); RegFileEnable_WB = 1; WriteDestination_WB = 9;
    rt_ID = 9; uses_rt_ID = 1; push();

    // Load-use stall.
    reset_cycle();
    advance(); clear_inputs(); set_load_use(); push();
    advance(); clear_inputs(); push();
    advance(); clear_inputs(); push();

    // Memory wait with a pending load-use, then the load-use stall follows.
    reset_cycle();
    mem_wait_cycles(3, 1);
    advance(); clear_inputs(); set_load_use(); mem_req_MEM = 1; mem_ready = 1; push();
    advance(); clear_inputs(); push();
    advance(); clear_inputs(); push();

    // Timeout at the 255th consecutive wait edge, sticky after release.
    reset_cycle();
    mem_wait_cycles(254, 0);
    advance(); clear_inputs(); push();
    mem_wait_cycles(256, 0);
    for (int i = 0; i < 3; i++) begin
      advance(); clear_inputs(); mem_req_MEM = 1; mem_ready = 1; push();
    end

    // Saturate stall_count, then one more load-use stall.
    mem_wait_cycles(65100, 0);
    advance(); clear_inputs(); set_load_use(); push();
    advance(); clear_inputs(); push();

    // Reset pulse in the middle of a wait, between edges.
    mem_wait_cycles(4, 0);
    advance(); clear_inputs(); mem_req_MEM = 1; reset = 1; set_load_use(); push();
    advance(); clear_inputs(); mem_req_MEM = 1; push();
    advance(); clear_inputs(); push();

    // Random traffic over a small register space so matches are frequent.
    for (int i = 0; i < 3000; i++) begin
      advance();
      reset = ($urandom_range(0, 99) == 0);
      rs_ID = 5'($urandom_range(0, 7)); rt_ID = 5'($urandom_range(0, 7));
      uses_rs_ID = 1'($urandom); uses_rt_ID = 1'($urandom);
      WriteDestination_EX = 5'($urandom_range(0, 7));
      WriteDestination_MEM = 5'($urandom_range(0, 7));
      WriteDestination_WB = 5'($urandom_range(0, 7));
      RegFileEnable_EX = 1'($urandom); RegFileEnable_MEM = 1'($urandom);
      RegFileEnable_WB = 1'($urandom);
      MemLoad_EX = 1'($urandom);
      mem_req_MEM = ($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom);
      push();
    end

    advance(); clear_inputs();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
